// File: rtl/a2d_pkg.sv
// a2d_pkg: shared types and helpers for the A2D round-robin scheduler.
// Holds the FSM/slot enums, default channel map and command builder.
package a2d_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    WAIT_SEL,
    DEAD,
    RD,
    WAIT_RD,
    STORE,
    GAP
  } a2d_state_t;

  typedef enum logic [1:0] {
    SLOT_LFT,
    SLOT_RGHT,
    SLOT_STEER,
    SLOT_BATT
  } slot_t;

  localparam logic [15:0] DFLT_GAP_CLKS  = 16'd1024;
  localparam logic [3:0]  DFLT_DEAD_CLKS = 4'd4;
  localparam logic [2:0]  DFLT_CH_LFT    = 3'd0;
  localparam logic [2:0]  DFLT_CH_RGHT   = 3'd4;
  localparam logic [2:0]  DFLT_CH_STEER  = 3'd5;
  localparam logic [2:0]  DFLT_CH_BATT   = 3'd6;

  function automatic logic [15:0] mk_cmd(
    input logic [2:0] chnl
  );
    return {2'b00, chnl, 11'h000};
  endfunction

endpackage

// File: rtl/a2d_tmr.sv
// a2d_tmr: loadable down-counter shared by the DEAD and GAP waits.
// Ports: clk_i, rst_i (async high), ld_i/ld_val_i load, expired_o at zero.
module a2d_tmr #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ld_i)
      cnt_d = ld_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/a2d_scheduler.sv
// a2d_scheduler: round-robin ADC128S conversion sequencer over the SPI master.
// Ports: clk, rst, en; spi_wrt/spi_cmd/spi_done/spi_rd_data; results, upd_vld, round_done.
module a2d_scheduler
  import a2d_pkg::*;
#(
  parameter logic [15:0] GAP_CLKS  = DFLT_GAP_CLKS,
  parameter logic [3:0]  DEAD_CLKS = DFLT_DEAD_CLKS,
  parameter logic [2:0]  CH_LFT    = DFLT_CH_LFT,
  parameter logic [2:0]  CH_RGHT   = DFLT_CH_RGHT,
  parameter logic [2:0]  CH_STEER  = DFLT_CH_STEER,
  parameter logic [2:0]  CH_BATT   = DFLT_CH_BATT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        spi_wrt,
  output logic [15:0] spi_cmd,
  input  logic        spi_done,
  input  logic [15:0] spi_rd_data,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic [3:0]  upd_vld,
  output logic        round_done
);

  a2d_state_t  state_q, state_d;
  slot_t       slot_q, slot_d;
  logic [15:0] cmd_q, cmd_d;
  logic [11:0] res_q [4];
  logic [11:0] res_d [4];
  logic [3:0]  upd_q, upd_d;
  logic        rdone_q, rdone_d;
  logic        tmr_ld;
  logic [15:0] tmr_val;
  logic        tmr_exp;
  logic        rd_hi_unused;

  // Upper nibble of the ADC frame carries no conversion data.
  assign rd_hi_unused = ^spi_rd_data[15:12];

  function automatic logic [2:0] slot_ch(
    input slot_t s
  );
    logic [2:0] c;
    unique case (s)
      SLOT_LFT:   c = CH_LFT;
      SLOT_RGHT:  c = CH_RGHT;
      SLOT_STEER: c = CH_STEER;
      SLOT_BATT:  c = CH_BATT;
      default:    c = CH_LFT;
    endcase
    return c;
  endfunction

  a2d_tmr #(
    .W(16)
  ) u_tmr (
    .clk_i     (clk),
    .rst_i     (rst),
    .ld_i      (tmr_ld),
    .ld_val_i  (tmr_val),
    .expired_o (tmr_exp)
  );

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cmd_d   = cmd_q;
    res_d   = res_q;
    upd_d   = '0;
    rdone_d = 1'b0;
    tmr_ld  = 1'b0;
    tmr_val = '0;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d = SEL;
          cmd_d   = mk_cmd(slot_ch(slot_q));
        end
      end
      SEL: state_d = WAIT_SEL;
      WAIT_SEL: begin
        // First frame returns the previous channel; drop it.
        if (spi_done) begin
          state_d = DEAD;
          tmr_ld  = 1'b1;
          tmr_val = {12'h000, DEAD_CLKS - 4'd1};
        end
      end
      DEAD: begin
        if (tmr_exp)
          state_d = RD;
      end
      RD: state_d = WAIT_RD;
      WAIT_RD: begin
        // Capture at done so the value and strobe appear together.
        if (spi_done) begin
          state_d       = STORE;
          res_d[slot_q] = spi_rd_data[11:0];
          upd_d[slot_q] = 1'b1;
          rdone_d       = (slot_q == SLOT_BATT);
        end
      end
      STORE: begin
        slot_d = slot_t'(slot_q + 2'd1);
        if (en) begin
          state_d = GAP;
          tmr_ld  = 1'b1;
          tmr_val = GAP_CLKS - 16'd1;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (!en) begin
          state_d = IDLE;
        end else if (tmr_exp) begin
          state_d = SEL;
          cmd_d   = mk_cmd(slot_ch(slot_q));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      slot_q  <= SLOT_LFT;
      cmd_q   <= 16'h0000;
      res_q   <= '{default: '0};
      upd_q   <= '0;
      rdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      cmd_q   <= cmd_d;
      res_q   <= res_d;
      upd_q   <= upd_d;
      rdone_q <= rdone_d;
    end
  end

  assign spi_wrt    = (state_q == SEL) || (state_q == RD);
  assign spi_cmd    = cmd_q;
  assign lft_ld     = res_q[SLOT_LFT];
  assign rght_ld    = res_q[SLOT_RGHT];
  assign steer_pot  = res_q[SLOT_STEER];
  assign batt       = res_q[SLOT_BATT];
  assign upd_vld    = upd_q;
  assign round_done = rdone_q;

endmodule

// File: tb/tb_a2d_scheduler.sv
// tb_a2d_scheduler: directed + randomized bench with an SPI/ADC responder.
// Model tracks expected slot order, command words and stored results.
module tb_a2d_scheduler;

  localparam int GAP  = 64;
  localparam int DEAD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        spi_wrt;
  logic [15:0] spi_cmd;
  logic        spi_done;
  logic [15:0] spi_rd_data;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;
  logic [3:0]  upd_vld;
  logic        round_done;

  always #5 clk = ~clk;

  a2d_scheduler #(
    .GAP_CLKS  (16'd64),
    .DEAD_CLKS (4'd4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .spi_wrt     (spi_wrt),
    .spi_cmd     (spi_cmd),
    .spi_done    (spi_done),
    .spi_rd_data (spi_rd_data),
    .lft_ld      (lft_ld),
    .rght_ld     (rght_ld),
    .steer_pot   (steer_pot),
    .batt        (batt),
    .upd_vld     (upd_vld),
    .round_done  (round_done)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] exp_cmd(input int s);
    logic [2:0] c;
    case (s)
      0: c = 3'd0;
      1: c = 3'd4;
      2: c = 3'd5;
      default: c = 3'd6;
    endcase
    return {2'b00, c, 11'h000};
  endfunction

  // ADC inputs indexed by channel
  logic [11:0] adc [8];
  // model state
  int          exp_slot = 0;
  int          phase = 0;
  int          cyc = 0;
  int          sel_done_cyc = 0;
  int          last_upd_cyc = 0;
  bit          gap_exempt = 1;
  bit          prev_wrt = 0;
  bit          just4;
  logic [15:0] held_cmd = '0;
  logic [11:0] conv_val = '0;
  logic [11:0] exp_res [4] = '{default: '0};
  int          viol = 0;
  int          rst_viol = 0;
  int          wrt_cnt = 0;
  int          rd_pulses = 0;
  logic [3:0]  upd_log [$];
  logic [15:0] cmd_log [$];
  bit          spur_en = 0;
  // responder state
  bit          busy = 0;
  int          dly = 0;
  logic [2:0]  cur_ch = '0;
  logic [2:0]  prev_ch = '0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (spi_wrt !== 1'b0 || upd_vld !== 4'h0 || round_done !== 1'b0 ||
          spi_cmd !== 16'h0 || lft_ld !== 12'h0 || rght_ld !== 12'h0 ||
          steer_pot !== 12'h0 || batt !== 12'h0)
        rst_viol++;
      exp_slot = 0;
      phase = 0;
      gap_exempt = 1;
      prev_wrt = 0;
      exp_res = '{default: '0};
      busy = 0;
      prev_ch = '0;
      spi_done = 1'b0;
    end else begin
      just4 = 0;
      if (!en) gap_exempt = 1;
      if (spi_wrt) begin
        wrt_cnt++;
        cmd_log.push_back(spi_cmd);
        if (prev_wrt) viol++;
        chk("cmd", spi_cmd, exp_cmd(exp_slot));
        held_cmd = spi_cmd;
        if (phase == 0) begin
          if (!gap_exempt) chk("gap", (cyc - last_upd_cyc) >= GAP, 1);
          gap_exempt = 0;
          phase = 1;
        end else if (phase == 2) begin
          chk("dead", (cyc - sel_done_cyc) >= DEAD, 1);
          phase = 3;
        end else begin
          viol++;
        end
      end else if (spi_done && phase == 1) begin
        phase = 2;
        sel_done_cyc = cyc;
      end else if (spi_done && phase == 3) begin
        phase = 4;
        just4 = 1;
        conv_val = spi_rd_data[11:0];
      end
      if ((phase == 1 || phase == 2 || phase == 3) && spi_cmd !== held_cmd)
        viol++;
      if (upd_vld !== 4'h0 || round_done !== 1'b0) begin
        upd_log.push_back(upd_vld);
        if (round_done) rd_pulses++;
        chk("upd_onehot", upd_vld, 4'b0001 << exp_slot);
        chk("upd_phase", phase, 4);
        chk("round_done", round_done, exp_slot == 3);
        exp_res[exp_slot] = conv_val;
        chk("results", {lft_ld, rght_ld, steer_pot, batt},
            {exp_res[0], exp_res[1], exp_res[2], exp_res[3]});
        exp_slot = (exp_slot + 1) % 4;
        phase = 0;
        last_upd_cyc = cyc;
      end else if (phase == 4 && !just4) begin
        viol++;
        phase = 0;
      end
      prev_wrt = spi_wrt;
      // SPI master + ADC128S responder: a frame returns the channel
      // addressed by the previous frame.
      spi_done = 1'b0;
      if (busy) begin
        dly--;
        if (dly == 0) begin
          spi_done = 1'b1;
          spi_rd_data = {4'($urandom), adc[prev_ch]};
          prev_ch = cur_ch;
          busy = 0;
        end
      end else if (spi_wrt) begin
        busy = 1;
        cur_ch = spi_cmd[13:11];
        dly = $urandom_range(2, 12);
      end else if (spur_en && $urandom_range(0, 29) == 0) begin
        spi_done = 1'b1;
        spi_rd_data = 16'($urandom);
      end
    end
  end

  bit ok;
  int w0;
  int r0;

  initial begin
    adc = '{default: '0};
    adc[0] = 12'h200;
    adc[4] = 12'h210;
    adc[5] = 12'h800;
    adc[6] = 12'hFFF;
    spi_done = 1'b0;
    spi_rd_data = '0;
    en = 1'b1;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("reset_outputs", rst_viol, 0);
    chk("reset_no_wrt", wrt_cnt, 0);
    rst = 1'b0;
    ok = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      if (wrt_cnt > 0) begin ok = 1; break; end
    end
    chk("first_wrt_latency", ok, 1);
    chk("first_cmd", spi_cmd, 16'h0000);

    // full round
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (rd_pulses >= 1) begin ok = 1; break; end
    end
    chk("round1_wait", ok, 1);
    chk("lft_ld", lft_ld, 12'h200);
    chk("rght_ld", rght_ld, 12'h210);
    chk("steer_pot", steer_pot, 12'h800);
    chk("batt", batt, 12'hFFF);
    chk("upd_order", {upd_log[0], upd_log[1], upd_log[2], upd_log[3]},
        16'h1248);
    chk("wrt_per_round", wrt_cnt, 8);
    begin
      logic [15:0] seq [8];
      seq = '{16'h0000, 16'h0000, 16'h2000, 16'h2000,
              16'h2800, 16'h2800, 16'h3000, 16'h3000};
      for (int i = 0; i < 8; i++) chk("cmd_seq", cmd_log[i], seq[i]);
    end

    // en drop mid-conversion of steer slot
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (phase == 1 && exp_slot == 2) begin ok = 1; break; end
    end
    chk("steer_sel_wait", ok, 1);
    @(negedge clk); #1;
    en = 1'b0;
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); #1;
      if (exp_slot == 3) begin ok = 1; break; end
    end
    chk("steer_complete", ok, 1);
    chk("steer_upd", upd_log[$], 4'b0100);
    w0 = wrt_cnt;
    repeat (300) @(negedge clk);
    #1;
    chk("idle_no_wrt", wrt_cnt, w0);
    chk("idle_hold", steer_pot, 12'h800);
    en = 1'b1;
    ok = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (wrt_cnt > w0) begin ok = 1; break; end
    end
    chk("reenable_wrt", ok, 1);
    chk("reenable_cmd", cmd_log[$], 16'h3000);

    // value change mid-round, three rounds, spurious done pulses
    spur_en = 1;
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (exp_slot == 2) begin ok = 1; break; end
    end
    chk("midround_wait", ok, 1);
    adc[6] = 12'h5A5;
    r0 = rd_pulses;
    ok = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk); #1;
      if (rd_pulses >= r0 + 3) begin ok = 1; break; end
    end
    chk("three_rounds_wait", ok, 1);
    chk("round_count", rd_pulses - r0, 3);
    chk("batt_new", batt, 12'h5A5);
    spur_en = 0;

    // async reset during WAIT_RD of rght slot
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (phase == 3 && exp_slot == 1 && !spi_wrt) begin ok = 1; break; end
    end
    chk("rght_wait_rd", ok, 1);
    chk("pre_rst_lft", lft_ld, 12'h200);
    #2 rst = 1'b1;
    #1;
    chk("async_lft", lft_ld, 12'h000);
    chk("async_batt", batt, 12'h000);
    chk("async_cmd", spi_cmd, 16'h0000);
    chk("async_wrt", spi_wrt, 1'b0);
    chk("async_upd", {upd_vld, round_done}, 5'h0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    w0 = wrt_cnt;
    ok = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (wrt_cnt > w0) begin ok = 1; break; end
    end
    chk("restart_wrt", ok, 1);
    chk("restart_cmd", cmd_log[$], 16'h0000);
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); #1;
      if (exp_slot == 1) begin ok = 1; break; end
    end
    chk("restart_upd_wait", ok, 1);
    chk("restart_upd", upd_log[$], 4'b0001);
    chk("restart_lft", lft_ld, 12'h200);

    chk("protocol_viol", viol, 0);
    chk("reset_viol", rst_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
